// File: rtl/cyclic_syndrome_checker.sv
// Serial cyclic-code syndrome checker: divides an n-bit codeword by g(x),
// MSB first, with an m-bit LFSR and reports syndrome, error flag and data.
//
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   in_valid/ready - word handshake; code_in and g sampled on accept only
//   code_in        - codeword, bit n-1 = x^(n-1) coefficient
//   g              - generator g_(m-1)..g_0, g_m = 1 implied
//   out_valid/ready- result handshake; outputs held while stalled
//   data_out       - code_in[n-1:m] of the accepted word
//   syndrome, err  - c(x) mod g(x) and its nonzero flag
module cyclic_syndrome_checker #(
    parameter int n = 15,
    parameter int k = 5,
    parameter int m = n - k
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] code_in,
    input  logic [m-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [k-1:0] data_out,
    output logic [m-1:0] syndrome,
    output logic         err
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [n-1:0]    sr;
    logic [m-1:0]    g_q;
    logic [m-1:0]    s;
    logic [CW-1:0]   cnt;
    logic            b;
    logic [m-1:0]    s_next;

    // One step of polynomial division: shift the next code bit in and
    // subtract (XOR) g whenever the x^m term falls out of the register.
    always_comb begin
        b      = sr[n-1];
        s_next = {s[m-2:0], b} ^ (s[m-1] ? g_q : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            g_q       <= '0;
            s         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            syndrome  <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // in_ready stays low on the release edge so it rises
                    // one cycle after reset is deasserted.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        sr       <= code_in;
                        g_q      <= g;
                        s        <= '0;
                        cnt      <= '0;
                        data_out <= code_in[n-1:m];
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= {sr[n-2:0], 1'b0};
                    s   <= s_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Result registers load from the final update so
                        // they are valid together with out_valid.
                        syndrome  <= s_next;
                        err       <= |s_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cyclic_syndrome_checker.md
# cyclic_syndrome_checker

Receive-side stage that consumes one n-bit word produced by `cyclic_encoder` and divides it serially, MSB first, by the generator polynomial g(x) with an m-bit LFSR. It reports the m-bit syndrome, a nonzero-syndrome error flag, and the k systematic data bits. Words enter and results leave through valid/ready handshakes, so the block can sit directly behind the encoder or behind a channel model in the bench.

## Interface
Parameters:
- `n`, default 15: codeword length in bits.
- `k`, default 5: data bits.
- `m`, default `n - k` (10): degree of g(x) and syndrome width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1: `code_in` and `g` are valid this cycle.
- `in_ready`  out  1: block can accept a word (high only in IDLE).
- `code_in`  in  n: codeword. Bit n-1 is the x^(n-1) coefficient. Bits [n-1:m] are the data and bits [m-1:0] are the parity.
- `g`  in  m: generator coefficients g_(m-1)..g_0. Bit i is the x^i coefficient; g_m = 1 is implicit.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: downstream accepts the result.
- `data_out`  out  k: `code_in[n-1:m]` of the accepted word.
- `syndrome`  out  m: c(x) mod g(x).
- `err`  out  1: `syndrome != 0`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - latch `code_in` into the shift register `sr` and `g` into `g_q`;
    - clear the syndrome register `s` to 0 and the bit counter `cnt` to 0;
    - go to SHIFT.
- **SHIFT**
  - Each cycle, take b = `sr[n-1]` and shift `sr` left by one.
  - Update the syndrome: `s` <= {`s[m-2:0]`, b} ^ (`s[m-1]` ? `g_q` : 0).
  - `cnt` increments. After the update with `cnt` == n-1, go to DONE.
  - Exactly n LFSR updates are performed.
- **DONE**
  - `out_valid` = 1. `syndrome` = `s`, `err` = |`s`, `data_out` = latched data bits.
  - Outputs are held stable while `out_ready` = 0.
  - On `out_ready` = 1, go to IDLE.
- **Width rules**
  - All arithmetic is GF(2) XOR.
  - `cnt` is $clog2(n) bits wide.
  - No truncation: the syndrome is exactly m bits.
- **Boundary conditions**
  - `g` and `code_in` are sampled only on the accept edge. Changes to `g` during SHIFT or DONE are ignored.
  - `in_valid` in SHIFT or DONE is ignored; the upstream block holds its word until `in_ready`.
  - `g_q` = 0 degenerates to syndrome = low m bits of the word. This is legal and gets no special handling.
  - Reset low in any state, including mid-SHIFT:
    - next state IDLE;
    - `s`, `sr`, `cnt` and `data_out` cleared;
    - the partial word is discarded and no result is produced.

## Timing
- Reset values:
  - `in_ready` = 0 while `reset` = 0, and 1 from the first cycle after release;
  - `out_valid` = 0, `syndrome` = 0, `err` = 0, `data_out` = 0.
- Accept edge E0. SHIFT updates occur on edges E1..En.
- `out_valid` rises after En, i.e. n cycles after acceptance.
- The DONE→IDLE transition happens on the edge where `out_valid && out_ready`. `in_ready` is high the following cycle.
- Minimum word period is n+2 cycles (accept, n shifts, one DONE cycle with `out_ready` = 1).
- A bench that drives `in_valid` only while `in_ready` = 1 sees back-to-back words accepted at that rate.
- `out_ready` held high: `out_valid` is a one-cycle pulse.
- No combinational path from `in_valid` or `out_ready` to any output.

## Test plan
All scenarios use n=15, k=5, m=10 and g = 10'h137 (x^10+x^8+x^5+x^4+x^2+x+1).
- Valid codeword `code_in` = 15'h0537 -> `out_valid` 15 cycles after accept, `syndrome` = 10'h000, `err` = 0, `data_out` = 5'b00001.
- Single-bit error, `code_in` = 15'h0536 (bit 0 flipped) -> `syndrome` = 10'h001, `err` = 1, `data_out` = 5'b00001.
- Error at bit 14, `code_in` = 15'h4537 -> `syndrome` = 10'h29B, `err` = 1, `data_out` = 5'b10001.
- Backpressure:
  - stimulus: hold `out_ready` = 0 for 5 cycles after `out_valid`; also toggle `g` and `code_in` during SHIFT;
  - required response: outputs stable and unchanged from the unperturbed result, `in_ready` = 0 throughout, and a single result is delivered.
- Reset mid-operation:
  - stimulus: drop `reset` for one cycle at the 7th SHIFT cycle of 15'h0536;
  - required response: `out_valid` never rises for that word, all outputs are 0, `in_ready` = 1 the next cycle, and 15'h0537 sent next gives `syndrome` = 0.
- Back-to-back stream:
  - stimulus: all-zero word, then 15'h0537, then 15'h0536, with `out_ready` = 1;
  - required response: syndromes 0, 0, 10'h001 in order, accepts spaced 17 cycles apart.
